vga_timing_gen: RTL and testbench

// - Upstream raster stage for snake_controller: 640x480@60 VGA sync generator on the 25 MHz pixel clock.
// - Generates the pixel coordinates (screenX/screenY) and the game-step strobe (refresh) that the controller consumes.
// - Takes back the controller's r/g/b, blanks it outside the active area and aligns it with hsync/vsync for the DAC pins.

---
 rtl/snake_pkg.sv | 52 +++++
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 tb/tb_vga_timing_gen.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake raster path: VGA 640x480@60 timing defaults,
// coordinate/colour widths and the play-field grid used by snake_controller.
package snake_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam bit VGA_SYNC_POL        = 1'b0;
   localparam int VGA_FRAMES_PER_MOVE = 6;
   localparam int VGA_PIPE_DELAY      = 1;

   localparam int SCREEN_X_W  = 10;
   localparam int SCREEN_Y_W  = 9;
   localparam int COLOR_W     = 4;
   localparam int CNT_W       = 10;
   localparam int FRAME_CNT_W = 8;

   localparam int GRID_W    = 30;
   localparam int GRID_H    = 22;
   localparam int CELL_PX   = 20;
   localparam int BORDER_PX = 20;

   // Signals that travel down the alignment delay line together.
   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
   } sync_bits_t;

   typedef struct packed {
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } rgb_t;

   // True while cnt lies in [lo, lo+len-1].
   function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                      input int lo,
                                      input int len);
      return (cnt >= CNT_W'(lo)) && (cnt < CNT_W'(lo + len));
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the sync generator, snake_controller and the DAC pins.
interface vga_timing_gen_if;
   import snake_pkg::*;

   // Free-running stream, no valid/ready: the generator presents a new
   // coordinate every pixel clock and the controller must return its colour
   // exactly PIPE_DELAY clocks later; there is no back-pressure.
   logic [SCREEN_X_W-1:0] screenX;
   logic [SCREEN_Y_W-1:0] screenY;
   logic                  active;
   logic                  refresh;
   logic [COLOR_W-1:0]    r_in;
   logic [COLOR_W-1:0]    g_in;
   logic [COLOR_W-1:0]    b_in;
   logic [COLOR_W-1:0]    vga_r;
   logic [COLOR_W-1:0]    vga_g;
   logic [COLOR_W-1:0]    vga_b;
   logic                  hsync;
   logic                  vsync;

   modport master (
      output screenX, screenY, active, refresh,
      output vga_r, vga_g, vga_b, hsync, vsync,
      input  r_in, g_in, b_in
   );

   modport slave (
      input  screenX, screenY, active, refresh,
      input  vga_r, vga_g, vga_b, hsync, vsync,
      output r_in, g_in, b_in
   );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async active-low reset to RESET_VAL.
// DEPTH=0 degenerates to a wire.
module vga_delay_line #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             vga_clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_clk_rst;
         assign unused_clk_rst = vga_clock ^ reset_n;
         assign dout = din;
      end else begin : g_shift
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge vga_clock or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel/line counters, game-step strobe, and blanking
// plus alignment of the controller's colour with hsync/vsync.
module vga_timing_gen
   import snake_pkg::*;
#(
   parameter int H_ACTIVE        = VGA_H_ACTIVE,
   parameter int H_FP            = VGA_H_FP,
   parameter int H_SYNC          = VGA_H_SYNC,
   parameter int H_BP            = VGA_H_BP,
   parameter int V_ACTIVE        = VGA_V_ACTIVE,
   parameter int V_FP            = VGA_V_FP,
   parameter int V_SYNC          = VGA_V_SYNC,
   parameter int V_BP            = VGA_V_BP,
   parameter bit SYNC_POL        = VGA_SYNC_POL,
   parameter int FRAMES_PER_MOVE = VGA_FRAMES_PER_MOVE,
   parameter int PIPE_DELAY      = VGA_PIPE_DELAY
) (
   input logic              vga_clock,
   input logic              reset_n,
   vga_timing_gen_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic [CNT_W-1:0]       h_cnt;
   logic [CNT_W-1:0]       v_cnt;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic                   refresh_q;
   logic                   h_last;
   logic                   v_last;
   logic                   vblank_entry;
   logic                   frame_end;

   assign h_last       = (h_cnt == CNT_W'(H_TOTAL - 1));
   assign v_last       = (v_cnt == CNT_W'(V_TOTAL - 1));
   assign vblank_entry = h_last && (v_cnt == CNT_W'(V_ACTIVE - 1));
   assign frame_end    = h_last && v_last;

   always_ff @(posedge vga_clock or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Game-step strobe: rises on every FRAMES_PER_MOVE-th entry into v-blank
   // and falls when the frame wraps, so the snake only moves while blanked.
   always_ff @(posedge vga_clock or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
         refresh_q <= 1'b0;
      end else if (vblank_entry) begin
         if (frame_cnt == FRAME_CNT_W'(FRAMES_PER_MOVE - 1)) begin
            frame_cnt <= '0;
            refresh_q <= 1'b1;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end else if (frame_end) begin
         refresh_q <= 1'b0;
      end
   end

   logic                  h_vis;
   logic                  v_vis;
   logic [SCREEN_X_W-1:0] screen_x;
   logic [SCREEN_Y_W-1:0] screen_y;
   sync_bits_t            sync_raw;
   sync_bits_t            sync_d;

   always_comb begin
      h_vis           = (h_cnt < CNT_W'(H_ACTIVE));
      v_vis           = (v_cnt < CNT_W'(V_ACTIVE));
      screen_x        = h_vis ? h_cnt : '0;
      screen_y        = v_vis ? v_cnt[SCREEN_Y_W-1:0] : '0;
      sync_raw.active = h_vis && v_vis;
      sync_raw.hs     = in_window(h_cnt, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
      sync_raw.vs     = in_window(v_cnt, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
   end

   // Matches the controller's colour latency so sync and pixel stay paired.
   vga_delay_line #(
      .WIDTH     (3),
      .DEPTH     (PIPE_DELAY),
      .RESET_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
   ) u_sync_delay (
      .vga_clock (vga_clock),
      .reset_n   (reset_n),
      .din       (sync_raw),
      .dout      (sync_d)
   );

   logic               hsync_q;
   logic               vsync_q;
   logic [COLOR_W-1:0] vga_r_q;
   logic [COLOR_W-1:0] vga_g_q;
   logic [COLOR_W-1:0] vga_b_q;

   always_ff @(posedge vga_clock or negedge reset_n) begin
      if (!reset_n) begin
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         vga_r_q <= '0;
         vga_g_q <= '0;
         vga_b_q <= '0;
      end else begin
         hsync_q <= sync_d.hs;
         vsync_q <= sync_d.vs;
         vga_r_q <= sync_d.active ? bus.r_in : '0;
         vga_g_q <= sync_d.active ? bus.g_in : '0;
         vga_b_q <= sync_d.active ? bus.b_in : '0;
      end
   end

   assign bus.screenX = screen_x;
   assign bus.screenY = screen_y;
   assign bus.active  = sync_raw.active;
   assign bus.refresh = refresh_q;
   assign bus.hsync   = hsync_q;
   assign bus.vsync   = vsync_q;
   assign bus.vga_r   = vga_r_q;
   assign bus.vga_g   = vga_g_q;
   assign bus.vga_b   = vga_b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunk raster (25x15) with three parameter
// sets, checked against a position-arithmetic model plus a hand-built table.
module tb_vga_timing_gen;
   import snake_pkg::*;

   localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VA = 8, VFP = 2, VSW = 2, VBP = 3;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FT = HT * VT;
   localparam int NI = 3;

   typedef struct packed {
      logic [9:0]  sx;
      logic [8:0]  sy;
      logic        act;
      logic        refr;
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } obs_t;

   typedef struct {
      int         t;
      logic [9:0] sx;
      logic [8:0] sy;
      logic       act;
      logic       hs;
      logic       vs;
      logic       refr;
      logic [3:0] vga;
   } vec_t;

   logic        vga_clock = 1'b0;
   logic        reset_n   = 1'b0;
   logic [11:0] rgb_drv [NI];
   int          checks    = 0;
   int          failures  = 0;
   int          cyc       = 0;

   // clock/reset
   always #20 vga_clock = ~vga_clock;

   vga_timing_gen_if bus_a ();
   vga_timing_gen_if bus_b ();
   vga_timing_gen_if bus_c ();

   assign bus_a.r_in = rgb_drv[0][11:8];
   assign bus_a.g_in = rgb_drv[0][7:4];
   assign bus_a.b_in = rgb_drv[0][3:0];
   assign bus_b.r_in = rgb_drv[1][11:8];
   assign bus_b.g_in = rgb_drv[1][7:4];
   assign bus_b.b_in = rgb_drv[1][3:0];
   assign bus_c.r_in = rgb_drv[2][11:8];
   assign bus_c.g_in = rgb_drv[2][7:4];
   assign bus_c.b_in = rgb_drv[2][3:0];

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .SYNC_POL(1'b0), .FRAMES_PER_MOVE(6), .PIPE_DELAY(1)
   ) dut_a (.vga_clock(vga_clock), .reset_n(reset_n), .bus(bus_a));

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .SYNC_POL(1'b0), .FRAMES_PER_MOVE(1), .PIPE_DELAY(0)
   ) dut_b (.vga_clock(vga_clock), .reset_n(reset_n), .bus(bus_b));

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .SYNC_POL(1'b0), .FRAMES_PER_MOVE(3), .PIPE_DELAY(2)
   ) dut_c (.vga_clock(vga_clock), .reset_n(reset_n), .bus(bus_c));

   function automatic int pd_of(input int i);
      case (i)
         0:       return 1;
         1:       return 0;
         default: return 2;
      endcase
   endfunction

   function automatic int fpm_of(input int i);
      case (i)
         0:       return 6;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic obs_t get_obs(input int i);
      obs_t o;
      case (i)
         0: o = {bus_a.screenX, bus_a.screenY, bus_a.active, bus_a.refresh,
                 bus_a.hsync, bus_a.vsync, bus_a.vga_r, bus_a.vga_g, bus_a.vga_b};
         1: o = {bus_b.screenX, bus_b.screenY, bus_b.active, bus_b.refresh,
                 bus_b.hsync, bus_b.vsync, bus_b.vga_r, bus_b.vga_g, bus_b.vga_b};
         default: o = {bus_c.screenX, bus_c.screenY, bus_c.active, bus_c.refresh,
                       bus_c.hsync, bus_c.vsync, bus_c.vga_r, bus_c.vga_g, bus_c.vga_b};
      endcase
      return o;
   endfunction

   // Reference: t is the number of clock edges since reset release; raster
   // position, sync windows and v-blank entry count all follow from t.
   function automatic obs_t model(input int t, input int pd, input int fpm,
                                  input logic [11:0] rgb);
      obs_t e;
      int   h, v, d, hd, vd, q, ent;
      logic vblank, ad;
      h = t % HT;
      v = (t / HT) % VT;
      e.sx  = (h < HA) ? 10'(h) : 10'd0;
      e.sy  = (v < VA) ? 9'(v) : 9'd0;
      e.act = (h < HA) && (v < VA);
      d = t - pd - 1;
      if (d < 0) begin
         e.hs = 1'b1;
         e.vs = 1'b1;
         ad   = 1'b0;
      end else begin
         hd   = d % HT;
         vd   = (d / HT) % VT;
         e.hs = !((hd >= HA + HFP) && (hd < HA + HFP + HSW));
         e.vs = !((vd >= VA + VFP) && (vd < VA + VFP + VSW));
         ad   = (hd < HA) && (vd < VA);
      end
      e.rgb  = ad ? rgb : 12'h000;
      q      = t % FT;
      vblank = (q >= VA * HT);
      ent    = t / FT + (vblank ? 1 : 0);
      e.refr = vblank && (ent > 0) && ((ent % fpm) == 0);
      return e;
   endfunction

   // scoreboard
   task automatic check_val(input string name, input logic [39:0] got,
                            input logic [39:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic check_models(input string tag);
      obs_t a, e;
      for (int i = 0; i < NI; i++) begin
         a = get_obs(i);
         e = model(cyc, pd_of(i), fpm_of(i), rgb_drv[i]);
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0d got=%h exp=%h", tag, i, cyc, a, e);
         end
      end
   endtask

   task automatic check_vec(input vec_t v);
      logic [39:0] got, exp;
      got = {5'd0, bus_a.screenX, bus_a.screenY, bus_a.active, bus_a.hsync,
             bus_a.vsync, bus_a.refresh, bus_a.vga_r, bus_a.vga_g, bus_a.vga_b};
      exp = {5'd0, v.sx, v.sy, v.act, v.hs, v.vs, v.refr, v.vga, v.vga, v.vga};
      check_val($sformatf("vec_t%0d", v.t), got, exp);
   endtask

   // driver / test sequence
   initial begin
      vec_t vecs[$];
      int   vi;
      int   rises [NI];
      logic prev_r [NI];
      int   first_rise_a;
      obs_t o;

      //           t     sx  sy act hs vs refr vga
      vecs.push_back('{0,    0,  0, 1, 1, 1, 0, 4'h0});
      vecs.push_back('{1,    1,  0, 1, 1, 1, 0, 4'h0});
      vecs.push_back('{2,    2,  0, 1, 1, 1, 0, 4'hF});
      vecs.push_back('{16,   0,  0, 0, 1, 1, 0, 4'hF});
      vecs.push_back('{17,   0,  0, 0, 1, 1, 0, 4'hF});
      vecs.push_back('{18,   0,  0, 0, 1, 1, 0, 4'h0});
      vecs.push_back('{19,   0,  0, 0, 1, 1, 0, 4'h0});
      vecs.push_back('{20,   0,  0, 0, 0, 1, 0, 4'h0});
      vecs.push_back('{23,   0,  0, 0, 0, 1, 0, 4'h0});
      vecs.push_back('{24,   0,  0, 0, 1, 1, 0, 4'h0});
      vecs.push_back('{25,   0,  1, 1, 1, 1, 0, 4'h0});
      vecs.push_back('{27,   2,  1, 1, 1, 1, 0, 4'hF});
      vecs.push_back('{200,  0,  0, 0, 1, 1, 0, 4'h0});
      vecs.push_back('{251,  1,  0, 0, 1, 1, 0, 4'h0});
      vecs.push_back('{252,  2,  0, 0, 1, 0, 0, 4'h0});
      vecs.push_back('{301,  1,  0, 0, 1, 0, 0, 4'h0});
      vecs.push_back('{302,  2,  0, 0, 1, 1, 0, 4'h0});
      vecs.push_back('{374,  0,  0, 0, 1, 1, 0, 4'h0});
      vecs.push_back('{375,  0,  0, 1, 1, 1, 0, 4'h0});
      vecs.push_back('{2074, 0,  7, 0, 1, 1, 0, 4'h0});
      vecs.push_back('{2075, 0,  0, 0, 1, 1, 1, 4'h0});
      vecs.push_back('{2180, 5,  0, 0, 1, 1, 1, 4'h0});

      for (int i = 0; i < NI; i++) rgb_drv[i] = 12'hFFF;

      // power-on reset
      cyc = 0;
      repeat (3) @(posedge vga_clock);
      #1;
      check_models("reset_hold");
      @(negedge vga_clock);
      #2 reset_n = 1'b1;

      vi = 0;
      while (vi < vecs.size() && vecs[vi].t == 0) begin
         check_vec(vecs[vi]);
         vi++;
      end

      // phase 1: constant white input, table plus model
      for (int t = 1; t <= 2180; t++) begin
         @(posedge vga_clock);
         #1;
         cyc = t;
         check_models("white");
         while (vi < vecs.size() && vecs[vi].t == t) begin
            check_vec(vecs[vi]);
            vi++;
         end
         if (failures > 40) break;
      end
      check_val("table_consumed", 40'(vi), 40'(vecs.size()));

      // mid-pulse asynchronous reset while refresh is high
      #5 reset_n = 1'b0;
      #1;
      cyc = 0;
      check_val("mid_rst_refresh", 40'(bus_a.refresh), 40'd0);
      check_val("mid_rst_syncs", 40'({bus_a.hsync, bus_a.vsync}), 40'h3);
      check_val("mid_rst_rgb", 40'({bus_a.vga_r, bus_a.vga_g, bus_a.vga_b}), 40'h0);
      check_val("mid_rst_xy", 40'({bus_a.screenX, bus_a.screenY}), 40'h0);
      check_models("mid_reset");
      @(posedge vga_clock);
      #1;
      check_models("reset_hold2");
      @(negedge vga_clock);
      #2 reset_n = 1'b1;
      check_models("post_release");

      // phase 2: random colour, model every clock, count refresh rises
      first_rise_a = -1;
      for (int i = 0; i < NI; i++) begin
         rises[i]  = 0;
         o         = get_obs(i);
         prev_r[i] = o.refr;
      end
      for (int t = 1; t <= 2300; t++) begin
         @(posedge vga_clock);
         #1;
         cyc = t;
         if (t == 1) check_val("first_x_after_reset", 40'(bus_a.screenX), 40'd1);
         check_models("rand");
         for (int i = 0; i < NI; i++) begin
            o = get_obs(i);
            if (o.refr && !prev_r[i]) begin
               rises[i]++;
               if (i == 0 && first_rise_a < 0) first_rise_a = t;
            end
            prev_r[i] = o.refr;
            rgb_drv[i] = 12'($urandom_range(0, 4095));
         end
         if (failures > 40) break;
      end
      check_val("first_rise_a", 40'(first_rise_a), 40'd2075);
      check_val("rises_fpm6", 40'(rises[0]), 40'd1);
      check_val("rises_fpm1", 40'(rises[1]), 40'd6);
      check_val("rises_fpm3", 40'(rises[2]), 40'd2);

      // report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
